tx_sweep_scheduler: RTL and testbench
=====================================

// Module: tx_sweep_scheduler
// PURPOSE
//  Sequences the transmit beamformer through a steering-angle sweep. Each frame is a sine ROM lookup,
//  then a burst with tx_enable high, then a listen window, then a step to the next angle.
//  Drives sin_value/sign_bit into transmit_beamformer and holds them stable all frame.
//  Sits between top-level control (enable/hold) and the beamformer/ROM.
// PARAMETERS
//  PERIOD_DURATION  16777216  cycles from burst start to end of listen window (must be > BURST_DURATION)
//  BURST_DURATION   524288    cycles tx_enable is high per frame (>=1)
//  MAX_ANGLE_IDX    15        sweep runs angle_idx -MAX_ANGLE_IDX..+MAX_ANGLE_IDX, step 1
//  SIN_WIDTH        17        width of sin_value (unsigned magnitude, matches beamformer)
//  ROM_LATENCY      2         cycles from sin_addr to valid sin_data (>=1)
// PORTS
//  clk_in        in   1                  system clock
//  rst_in        in   1                  synchronous, active-low reset
//  enable        in   1                  run sweep; sampled in IDLE and at frame end
//  hold          in   1                  1 = repeat current angle at frame end (no advance)
//  sin_addr      out  ANGLE_W-1          ROM address = |angle_idx|
//  sin_data      in   SIN_WIDTH          ROM read data, valid ROM_LATENCY cycles after sin_addr
//  sin_value     out  SIN_WIDTH          registered magnitude to beamformer
//  sign_bit      out  1                  1 = angle_idx<0 (steer left), to beamformer
//  angle_idx     out  ANGLE_W (signed)   current angle; ANGLE_W = $clog2(MAX_ANGLE_IDX+1)+1
//  tx_enable     out  1                  gates beamformer tx_out; high only in BURST
//  listen_active out  1                  high only in LISTEN (receive window)
//  burst_start   out  1                  1-cycle pulse, first BURST cycle
//  sweep_done    out  1                  1-cycle pulse when angle wraps +MAX -> -MAX
// BEHAVIOUR
//  Reset (rst_in==0 at posedge): state=IDLE, angle_idx=-MAX_ANGLE_IDX, sin_value=0, sign_bit=0,
//   sin_addr=0, all flags/pulses 0, counters 0. Reset takes effect the same edge in every state (abort).
//  States: IDLE -> LOAD -> BURST -> LISTEN -> (LOAD | IDLE).
//  IDLE: sin_addr driven from angle_idx; if enable=1 -> LOAD next cycle.
//  LOAD: sin_addr=|angle_idx| held; wait counter runs ROM_LATENCY cycles; on the last LOAD cycle
//   sin_data is captured into sin_value and sign_bit<=(angle_idx<0); -> BURST.
//   sin_value/sign_bit change ONLY at this capture; stable through BURST and LISTEN.
//  BURST: tx_enable=1; burst_start=1 on first cycle only; period counter starts at 0 on BURST entry,
//   +1/cycle; after BURST_DURATION cycles (count==BURST_DURATION-1) -> LISTEN.
//  LISTEN: listen_active=1; at count==PERIOD_DURATION-1 frame ends:
//   hold=1 -> angle unchanged; else angle_idx+1, wrapping +MAX -> -MAX with sweep_done pulse
//   (pulse in the cycle after the frame end, with the new angle_idx visible).
//   enable=1 -> LOAD; enable=0 -> IDLE (angle still advanced/held as above).
//  Frame length = ROM_LATENCY + PERIOD_DURATION cycles; back-to-back frames have no gap.
//  enable dropping during LOAD/BURST/LISTEN does NOT truncate the frame; the frame completes first.
//  hold sampled only at frame end. MAX_ANGLE_IDX=0: angle_idx fixed at 0; sweep_done pulses every frame.
//  Period counter width $clog2(PERIOD_DURATION); no overflow since it clears on each BURST entry.
//  tx_enable and listen_active never high in the same cycle; both 0 in IDLE and LOAD.
// TESTING (PERIOD=100, BURST=20, MAX_ANGLE_IDX=2, ROM_LATENCY=2, ROM returns sin_data=addr*1000)
//  Reset: hold rst_in=0 3 cycles with enable=1 -> all outputs 0, angle_idx=-2, state IDLE.
//  Single frame: enable=1 at t0 -> LOAD t1..t2, sin_addr=2; sin_value=2000, sign_bit=1 from t3;
//   tx_enable high t3..t22, burst_start at t3 only; listen_active t23..t102; LOAD again t103.
//  Sweep order: enable held -> angle_idx -2,-1,0,1,2,-2; sign_bit 1,1,0,0,0,1; sweep_done one pulse at wrap.
//  Hold: hold=1 at frame end -> same angle_idx and sin_value next frame; hold=0 -> advances.
//  Graceful stop: drop enable mid-BURST -> burst stays 20 cycles, LISTEN completes, then IDLE,
//   angle advanced by 1, tx_enable=0.
//  Reset mid-BURST: rst_in=0 at burst cycle 5 -> next edge tx_enable=0, angle_idx=-2, IDLE.

Source files
------------

// File: rtl/tx_sweep_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : tx_sweep_scheduler_if
// Brief    : Control, sine-ROM and beamformer signals of the sweep scheduler.
// Revision : 1.0  initial release
// ============================================================================
interface tx_sweep_scheduler_if #(
    parameter int MAX_ANGLE_IDX = 15,
    parameter int SIN_WIDTH     = 17
);
    localparam int c_ANGLE_W = $clog2(MAX_ANGLE_IDX + 1) + 1;
    localparam int c_ADDR_W  = (c_ANGLE_W > 1) ? c_ANGLE_W - 1 : 1;

    logic                        enable;
    logic                        hold;
    logic [c_ADDR_W-1:0]         sin_addr;
    logic [SIN_WIDTH-1:0]        sin_data;
    logic [SIN_WIDTH-1:0]        sin_value;
    logic                        sign_bit;
    logic signed [c_ANGLE_W-1:0] angle_idx;
    logic                        tx_enable;
    logic                        listen_active;
    logic                        burst_start;
    logic                        sweep_done;

    modport master (
        input  enable, hold, sin_data,
        output sin_addr, sin_value, sign_bit, angle_idx,
               tx_enable, listen_active, burst_start, sweep_done
    );

    modport slave (
        output enable, hold, sin_data,
        input  sin_addr, sin_value, sign_bit, angle_idx,
               tx_enable, listen_active, burst_start, sweep_done
    );
endinterface
`default_nettype wire

// File: rtl/tx_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tx_sweep_scheduler
// Brief    : Steps the transmit beamformer through an angle sweep, one
//            LOAD / BURST / LISTEN frame per steering angle.
// Revision : 1.0  initial release
// ============================================================================
module tx_sweep_scheduler #(
    parameter int PERIOD_DURATION = 16777216,
    parameter int BURST_DURATION  = 524288,
    parameter int MAX_ANGLE_IDX   = 15,
    parameter int SIN_WIDTH       = 17,
    parameter int ROM_LATENCY     = 2
) (
    input wire                   clk_in,
    input wire                   rst_in,
    tx_sweep_scheduler_if.master bus
);
    localparam int c_ANGLE_W = $clog2(MAX_ANGLE_IDX + 1) + 1;
    localparam int c_ADDR_W  = (c_ANGLE_W > 1) ? c_ANGLE_W - 1 : 1;
    localparam int c_CNT_W   = (PERIOD_DURATION > 1) ? $clog2(PERIOD_DURATION) : 1;
    localparam int c_LAT_W   = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

    localparam logic signed [c_ANGLE_W-1:0] c_ANGLE_MAX = c_ANGLE_W'(MAX_ANGLE_IDX);
    localparam logic signed [c_ANGLE_W-1:0] c_ANGLE_MIN = -c_ANGLE_MAX;
    localparam logic signed [c_ANGLE_W-1:0] c_ANGLE_ONE = c_ANGLE_W'(1);
    localparam logic [c_CNT_W-1:0]          c_BURST_LAST  = c_CNT_W'(BURST_DURATION - 1);
    localparam logic [c_CNT_W-1:0]          c_PERIOD_LAST = c_CNT_W'(PERIOD_DURATION - 1);
    localparam logic [c_CNT_W-1:0]          c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [c_LAT_W-1:0]          c_LAT_LAST    = c_LAT_W'(ROM_LATENCY - 1);
    localparam logic [c_LAT_W-1:0]          c_LAT_ONE     = c_LAT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_BURST  = 2'd2,
        S_LISTEN = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic signed [c_ANGLE_W-1:0] r_angle;
    logic signed [c_ANGLE_W-1:0] w_angle_next;
    logic [c_ADDR_W-1:0]         r_sin_addr;
    logic [c_ADDR_W-1:0]         w_addr_next;
    logic [SIN_WIDTH-1:0]        r_sin_value;
    logic                        r_sign_bit;
    logic                        r_sweep_done;
    logic [c_CNT_W-1:0]          r_period_cnt;
    logic [c_LAT_W-1:0]          r_lat_cnt;
    logic                        w_load_done;
    logic                        w_wrap;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_angle_next = r_angle;
        w_load_done  = 1'b0;
        w_wrap       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.enable) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                if (r_lat_cnt == c_LAT_LAST) begin
                    w_load_done  = 1'b1;
                    w_state_next = S_BURST;
                end
            end
            S_BURST: begin
                if (r_period_cnt == c_BURST_LAST) w_state_next = S_LISTEN;
            end
            S_LISTEN: begin
                // Frame end: enable and hold are only honoured here, never mid-frame.
                if (r_period_cnt == c_PERIOD_LAST) begin
                    w_state_next = bus.enable ? S_LOAD : S_IDLE;
                    if (!bus.hold) begin
                        if (r_angle == c_ANGLE_MAX) begin
                            w_wrap       = 1'b1;
                            w_angle_next = c_ANGLE_MIN;
                        end else begin
                            w_angle_next = r_angle + c_ANGLE_ONE;
                        end
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // |angle| fits in the low bits, so a two's-complement negate of the slice suffices.
    assign w_addr_next = w_angle_next[c_ANGLE_W-1] ? -w_angle_next[c_ADDR_W-1:0]
                                                   :  w_angle_next[c_ADDR_W-1:0];

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_angle      <= c_ANGLE_MIN;
            r_sin_addr   <= '0;
            r_sin_value  <= '0;
            r_sign_bit   <= 1'b0;
            r_sweep_done <= 1'b0;
            r_period_cnt <= '0;
            r_lat_cnt    <= '0;
        end else begin
            r_angle      <= w_angle_next;
            r_sin_addr   <= w_addr_next;
            r_sweep_done <= w_wrap;
            r_lat_cnt    <= ((r_state == S_LOAD) && !w_load_done) ? r_lat_cnt + c_LAT_ONE : '0;
            if ((r_state == S_BURST) || (r_state == S_LISTEN)) begin
                r_period_cnt <= r_period_cnt + c_CNT_ONE;
            end else begin
                r_period_cnt <= '0;
            end
            if (w_load_done) begin
                r_sin_value <= bus.sin_data;
                r_sign_bit  <= r_angle[c_ANGLE_W-1];
            end
        end
    end

    assign bus.sin_addr      = r_sin_addr;
    assign bus.sin_value     = r_sin_value;
    assign bus.sign_bit      = r_sign_bit;
    assign bus.angle_idx     = r_angle;
    assign bus.tx_enable     = (r_state == S_BURST);
    assign bus.listen_active = (r_state == S_LISTEN);
    assign bus.burst_start   = (r_state == S_BURST) && (r_period_cnt == '0);
    assign bus.sweep_done    = r_sweep_done;

endmodule
`default_nettype wire

// File: tb/tb_tx_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_sweep_scheduler
// Brief    : Self-checking bench for tx_sweep_scheduler with a frame scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_tx_sweep_scheduler;
    localparam int PERIOD = 100;
    localparam int BURST  = 20;
    localparam int MAXA   = 2;
    localparam int LAT    = 2;
    localparam int SW     = 17;

    typedef struct packed {
        logic signed [2:0] angle;
        logic [SW-1:0]     val;
        logic              sgn;
        logic [7:0]        blen;
        logic [7:0]        llen;
        logic              ok;
    } frame_t;

    logic clk_in;
    logic rst_in;
    int   n_cmp = 0;
    int   n_err = 0;

    frame_t exp_q[$];
    frame_t obs_q[$];
    frame_t cur;
    frame_t e;
    frame_t o;
    logic   mon_active = 1'b0;
    logic   prev_ls    = 1'b0;
    int     sd_cnt     = 0;
    int     sd_angle   = 0;
    logic [SW-1:0] rom_q;

    tx_sweep_scheduler_if #(.MAX_ANGLE_IDX(MAXA), .SIN_WIDTH(SW)) bus ();

    tx_sweep_scheduler #(
        .PERIOD_DURATION(PERIOD),
        .BURST_DURATION (BURST),
        .MAX_ANGLE_IDX  (MAXA),
        .SIN_WIDTH      (SW),
        .ROM_LATENCY    (LAT)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Sine ROM stand-in: one register stage after the registered address.
    always @(posedge clk_in) rom_q <= SW'(int'(bus.sin_addr) * 1000);
    assign bus.sin_data = rom_q;

    function automatic frame_t mk(input int a);
        frame_t f;
        f.angle = 3'(a);
        f.val   = SW'((a < 0 ? -a : a) * 1000);
        f.sgn   = (a < 0);
        f.blen  = 8'(BURST);
        f.llen  = 8'(PERIOD - BURST);
        f.ok    = 1'b1;
        return f;
    endfunction

    // Frame monitor: records each completed frame as seen on the outputs.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            mon_active = 1'b0;
            prev_ls    = 1'b0;
        end else begin
            if (bus.burst_start) begin
                cur.angle  = bus.angle_idx;
                cur.val    = bus.sin_value;
                cur.sgn    = bus.sign_bit;
                cur.blen   = 8'd0;
                cur.llen   = 8'd0;
                cur.ok     = 1'b1;
                mon_active = 1'b1;
            end
            if (mon_active) begin
                if (bus.tx_enable)     cur.blen = cur.blen + 8'd1;
                if (bus.listen_active) cur.llen = cur.llen + 8'd1;
                if (bus.sin_value !== cur.val || bus.sign_bit !== cur.sgn ||
                    (bus.tx_enable && bus.listen_active)) cur.ok = 1'b0;
                if (prev_ls && !bus.listen_active) begin
                    obs_q.push_back(cur);
                    mon_active = 1'b0;
                end
            end
            prev_ls = bus.listen_active;
            if (bus.sweep_done) begin
                sd_cnt   = sd_cnt + 1;
                sd_angle = bus.angle_idx;
            end
        end
    end

    task automatic test_reset();
        bus.enable = 1'b1;
        bus.hold   = 1'b0;
        rst_in     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            n_cmp++;
            if ({bus.tx_enable, bus.listen_active, bus.burst_start, bus.sweep_done,
                 bus.sin_addr, bus.sin_value, bus.sign_bit} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs cyc%0d: got tx=%0b ls=%0b bs=%0b sd=%0b addr=%0d val=%0d sign=%0b, expected all 0",
                         i, bus.tx_enable, bus.listen_active, bus.burst_start, bus.sweep_done,
                         bus.sin_addr, bus.sin_value, bus.sign_bit);
            end
            n_cmp++;
            if (bus.angle_idx !== -3'sd2) begin
                n_err++;
                $display("FAIL reset_angle cyc%0d: got %0d, expected -2", i, bus.angle_idx);
            end
        end
        bus.enable = 1'b0;
        rst_in     = 1'b1;
        repeat (3) @(negedge clk_in);
        n_cmp++;
        if ({bus.tx_enable, bus.sin_addr, bus.angle_idx} !== {1'b0, 2'd2, -3'sd2}) begin
            n_err++;
            $display("FAIL idle_after_reset: got tx=%0b addr=%0d angle=%0d, expected tx=0 addr=2 angle=-2",
                     bus.tx_enable, bus.sin_addr, bus.angle_idx);
        end
    endtask

    task automatic test_single_frame();
        logic [22:0] got;
        logic [22:0] want;
        exp_q.push_back(mk(-2));
        bus.enable = 1'b1;
        for (int c = 1; c <= 103; c++) begin
            @(negedge clk_in);
            got  = {bus.tx_enable, bus.listen_active, bus.burst_start, bus.sin_addr,
                    bus.sin_value, bus.sign_bit};
            want = {(c >= 3 && c <= 22), (c >= 23 && c <= 102), (c == 3),
                    (c <= 102) ? 2'd2 : 2'd1,
                    (c >= 3) ? 17'd2000 : 17'd0, (c >= 3)};
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL frame_timeline t%0d: got tx/ls/bs/addr/val/sign=%h, expected %h", c, got, want);
            end
        end
        for (int i = 0; i < 10 && obs_q.size() < 1; i++) @(negedge clk_in);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL single_frame: got angle=%0d val=%0d sign=%0b burst=%0d listen=%0d stable=%0b, expected angle=%0d val=%0d sign=%0b burst=%0d listen=%0d stable=1",
                         o.angle, o.val, o.sgn, o.blen, o.llen, o.ok, e.angle, e.val, e.sgn, e.blen, e.llen);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL single_frame_timeout: got %0d frames pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_sweep_order();
        int a[5] = '{-1, 0, 1, 2, -2};
        foreach (a[k]) exp_q.push_back(mk(a[k]));
        for (int i = 0; i < 6 * 110 && obs_q.size() < 5; i++) @(negedge clk_in);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL sweep_frame: got angle=%0d val=%0d sign=%0b burst=%0d listen=%0d stable=%0b, expected angle=%0d val=%0d sign=%0b burst=%0d listen=%0d stable=1",
                         o.angle, o.val, o.sgn, o.blen, o.llen, o.ok, e.angle, e.val, e.sgn, e.blen, e.llen);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sweep_timeout: got %0d frames pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        n_cmp++;
        if (sd_cnt != 1 || sd_angle != -2) begin
            n_err++;
            $display("FAIL sweep_done: got %0d pulses at angle %0d, expected 1 pulse at angle -2", sd_cnt, sd_angle);
        end
    endtask

    task automatic test_hold();
        bus.hold = 1'b1;
        exp_q.push_back(mk(-1));
        exp_q.push_back(mk(-1));
        exp_q.push_back(mk(0));
        for (int i = 0; i < 150 && obs_q.size() < 1; i++) @(negedge clk_in);
        bus.hold = 1'b0;
        for (int i = 0; i < 3 * 110 && obs_q.size() < 3; i++) @(negedge clk_in);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL hold_frame: got angle=%0d val=%0d sign=%0b burst=%0d listen=%0d stable=%0b, expected angle=%0d val=%0d sign=%0b burst=%0d listen=%0d stable=1",
                         o.angle, o.val, o.sgn, o.blen, o.llen, o.ok, e.angle, e.val, e.sgn, e.blen, e.llen);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || sd_cnt != 1) begin
            n_err++;
            $display("FAIL hold_pending: got %0d frames pending and %0d sweep pulses, expected 0 and 1", exp_q.size(), sd_cnt);
            exp_q.delete();
        end
    endtask

    task automatic test_graceful_stop();
        logic found = 1'b0;
        int   tx_cnt = 0;
        for (int i = 0; i < 150 && !found; i++) begin
            @(negedge clk_in);
            found = bus.burst_start;
        end
        repeat (5) @(negedge clk_in);
        bus.enable = 1'b0;
        exp_q.push_back(mk(1));
        for (int i = 0; i < 150 && obs_q.size() < 1; i++) @(negedge clk_in);
        n_cmp++;
        if ({bus.tx_enable, bus.listen_active, bus.angle_idx, bus.sin_addr} !== {2'b00, 3'sd2, 2'd2}) begin
            n_err++;
            $display("FAIL stop_idle: got tx=%0b ls=%0b angle=%0d addr=%0d, expected tx=0 ls=0 angle=2 addr=2",
                     bus.tx_enable, bus.listen_active, bus.angle_idx, bus.sin_addr);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL stop_frame: got angle=%0d val=%0d sign=%0b burst=%0d listen=%0d stable=%0b, expected angle=%0d val=%0d sign=%0b burst=%0d listen=%0d stable=1",
                         o.angle, o.val, o.sgn, o.blen, o.llen, o.ok, e.angle, e.val, e.sgn, e.blen, e.llen);
            end
        end
        repeat (120) begin
            @(negedge clk_in);
            if (bus.tx_enable || bus.listen_active) tx_cnt++;
        end
        n_cmp++;
        if (tx_cnt != 0 || exp_q.size() != 0 || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL stop_quiet: got %0d active cycles, %0d/%0d frames pending, expected 0 and 0/0",
                     tx_cnt, exp_q.size(), obs_q.size());
            exp_q.delete();
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid_burst();
        logic found = 1'b0;
        bus.enable = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_in);
            found = bus.burst_start;
        end
        n_cmp++;
        if (!found || bus.angle_idx !== 3'sd2) begin
            n_err++;
            $display("FAIL restart_burst: got started=%0b angle=%0d, expected started=1 angle=2", found, bus.angle_idx);
        end
        repeat (5) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        n_cmp++;
        if ({bus.tx_enable, bus.listen_active, bus.burst_start, bus.angle_idx, bus.sin_value, bus.sign_bit}
            !== {3'b000, -3'sd2, 17'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid_burst: got tx=%0b ls=%0b bs=%0b angle=%0d val=%0d sign=%0b, expected tx=0 ls=0 bs=0 angle=-2 val=0 sign=0",
                     bus.tx_enable, bus.listen_active, bus.burst_start, bus.angle_idx, bus.sin_value, bus.sign_bit);
        end
        bus.enable = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (5) @(negedge clk_in);
        n_cmp++;
        if (bus.tx_enable !== 1'b0 || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL reset_abort: got tx=%0b and %0d recorded frames, expected tx=0 and 0", bus.tx_enable, obs_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_sweep_order();
        test_hold();
        test_graceful_stop();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
